pe_mac_seq: RTL and testbench

Sequencing controller for the 8-lane vector MAC processing element (PE: `c_ab <= a*b + c` per lane, one-cycle registered latency, no enable, no reset). Given a command with a base address and beat count, it reads operand vectors from the operand buffers, steers the PE's `c` input between zero and `c_ab` feedback to accumulate across beats, and holds the result for a valid/ready handoff. The controller never touches data: it drives only buffer read controls and the datapath mux selects around one PE.

---
 rtl/pe_mac_seq_if.sv | 31 +++
 rtl/pe_mac_seq.sv | 91 +++++++++
 tb/tb_pe_mac_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_mac_seq_if.sv
// Command, operand-read and result-handoff signals of the PE sequencing controller.
// Handshake rule: a transfer happens on a rising edge where valid && ready; the offering side
// holds its payload stable until then, and ready never depends on valid in the same cycle.
interface pe_mac_seq_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [LEN_W-1:0]  cmd_len;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              op_zero;
  logic              c_sel;
  logic              res_valid;
  logic              res_ready;
  logic              err;
  logic              busy;
  logic [2:0]        dbg_state;

  modport master (
    output cmd_valid, cmd_base, cmd_len, res_ready,
    input  cmd_ready, rd_en, rd_addr, op_zero, c_sel, res_valid, err, busy, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_base, cmd_len, res_ready,
    output cmd_ready, rd_en, rd_addr, op_zero, c_sel, res_valid, err, busy, dbg_state
  );
endinterface

// File: rtl/pe_mac_seq.sv
// Sequencer for one 8-lane MAC PE: issues K operand reads, steers the PE accumulator input,
// and holds the result until the consumer takes it. Never touches the data itself.
module pe_mac_seq #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  pe_mac_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_HOLD  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_left;
  logic              r_cmd_ready;
  logic              r_issue_first;
  logic              r_rd_d;
  logic              r_c_sel;
  logic              w_accept;
  logic              w_len_zero;
  logic              w_last_beat;

  // cmd_ready is registered, so it is only ever high while the FSM sits in IDLE.
  assign w_accept    = bus.cmd_valid && r_cmd_ready;
  assign w_len_zero  = (bus.cmd_len == '0);
  assign w_last_beat = (r_left == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_len_zero ? S_ERR : S_ISSUE;
      S_ISSUE: if (w_last_beat) w_next = S_DRAIN;
      S_DRAIN: w_next = S_HOLD;
      S_HOLD:  if (bus.res_ready) w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Mux selects trail rd_en by one cycle so they line up with the returned read data.
  // Reset drives op_zero=1, c_sel=0, which loads zero into the PE accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr        <= '0;
      r_left        <= '0;
      r_cmd_ready   <= 1'b0;
      r_issue_first <= 1'b0;
      r_rd_d        <= 1'b0;
      r_c_sel       <= 1'b0;
    end else begin
      r_cmd_ready   <= (w_next == S_IDLE);
      r_issue_first <= w_accept && !w_len_zero;
      r_rd_d        <= (r_state == S_ISSUE);
      r_c_sel       <= !r_issue_first;
      if (w_accept) begin
        r_addr <= bus.cmd_base;
        r_left <= bus.cmd_len;
      end else if (r_state == S_ISSUE) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_left <= r_left - LEN_W'(1);
      end
    end
  end

  always_comb begin
    bus.cmd_ready = r_cmd_ready;
    bus.rd_en     = (r_state == S_ISSUE);
    bus.rd_addr   = r_addr;
    bus.op_zero   = !r_rd_d;
    bus.c_sel     = r_c_sel;
    bus.res_valid = (r_state == S_HOLD);
    bus.err       = (r_state == S_ERR);
    bus.busy      = (r_state != S_IDLE);
    bus.dbg_state = r_state;
  end

endmodule

// File: tb/tb_pe_mac_seq.sv
// Bench for pe_mac_seq: operand buffers and an 8-lane PE around the controller, directed
// scenarios plus random commands checked against a sum-of-products reference.
module tb_pe_mac_seq;

  logic clk;
  logic rst;

  pe_mac_seq_if #(.ADDR_W(8), .LEN_W(8)) bus ();

  pe_mac_seq #(.ADDR_W(8), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- environment: buffers and PE ----------------
  logic [7:0]  mem_a [256][8];
  logic [7:0]  mem_b [256][8];
  logic [7:0]  rd_a  [8];
  logic [7:0]  rd_b  [8];
  logic [15:0] c_ab  [8];

  always @(posedge clk) begin
    for (int l = 0; l < 8; l++) begin
      if (bus.rd_en) begin
        rd_a[l] <= mem_a[bus.rd_addr][l];
        rd_b[l] <= mem_b[bus.rd_addr][l];
      end
      c_ab[l] <= (bus.op_zero ? 16'd0 : 16'(rd_a[l]) * 16'(rd_b[l])) +
                 (bus.c_sel ? c_ab[l] : 16'd0);
    end
  end

  function automatic logic [127:0] cab_vec();
    logic [127:0] v;
    for (int l = 0; l < 8; l++) v[l*16 +: 16] = c_ab[l];
    return v;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [127:0] model(input logic [7:0] base, input int len);
    logic [127:0] v;
    logic [31:0]  s;
    logic [7:0]   ad;
    v = '0;
    for (int l = 0; l < 8; l++) begin
      s = 32'd0;
      for (int i = 0; i < len; i++) begin
        ad = base + 8'(i);
        s  = s + 32'(mem_a[ad][l]) * 32'(mem_b[ad][l]);
      end
      v[l*16 +: 16] = s[15:0];
    end
    return v;
  endfunction

  task automatic set_vec(input logic [7:0] addr, input logic [7:0] a, input logic [7:0] b);
    for (int l = 0; l < 8; l++) begin
      mem_a[addr][l] = a;
      mem_b[addr][l] = b;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0]   exp_q[$];
  logic [127:0] exp_cab;
  int           n_total;
  int           n_pass;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic run_cmd(input logic [7:0] base, input int len, input int stall);
    int          guard;
    logic [7:0]  a;
    logic [127:0] held;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 64) begin
      cycle();
      guard++;
    end
    chk("cmd_ready_wait", bus.cmd_ready, 1'b1);
    for (int i = 0; i < len; i++) exp_q.push_back(base + 8'(i));
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = base;
    bus.cmd_len   = 8'(len);
    bus.res_ready = (stall == 0);
    cycle();
    bus.cmd_valid = 1'b0;
    if (len == 0) begin
      chk("err_pulse", bus.err, 1'b1);
      chk("err_no_rd", bus.rd_en, 1'b0);
      chk("err_busy", bus.busy, 1'b1);
      cycle();
      chk("err_clear", bus.err, 1'b0);
      chk("err_no_rd2", bus.rd_en, 1'b0);
      chk("err_no_res", bus.res_valid, 1'b0);
      chk("err_ready", bus.cmd_ready, 1'b1);
      chk("err_cab", cab_vec(), exp_cab);
      return;
    end
    for (int t = 1; t <= len + 1; t++) begin
      chk("rd_en", bus.rd_en, t <= len);
      if (t <= len) begin
        a = exp_q.pop_front();
        chk("rd_addr", bus.rd_addr, a);
      end
      chk("op_zero", bus.op_zero, t < 2);
      chk("c_sel", bus.c_sel, t != 2);
      chk("res_early", bus.res_valid, 1'b0);
      chk("ready_busy", bus.cmd_ready, 1'b0);
      cycle();
    end
    exp_cab = model(base, len);
    chk("res_valid", bus.res_valid, 1'b1);
    chk("c_ab", cab_vec(), exp_cab);
    held = cab_vec();
    for (int s = 0; s < stall; s++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_base  = 8'($urandom);
      bus.cmd_len   = 8'($urandom_range(1, 4));
      cycle();
      chk("hold_valid", bus.res_valid, 1'b1);
      chk("hold_cab", cab_vec(), held);
      chk("hold_ignore", bus.cmd_ready, 1'b0);
      chk("hold_no_rd", bus.rd_en, 1'b0);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    cycle();
    chk("res_done", bus.res_valid, 1'b0);
    chk("ready_after", bus.cmd_ready, 1'b1);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_cab", cab_vec(), exp_cab);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_total = 0;
    n_pass  = 0;
    exp_cab = '0;
    for (int ad = 0; ad < 256; ad++)
      for (int l = 0; l < 8; l++) begin
        mem_a[ad][l] = 8'($urandom);
        mem_b[ad][l] = 8'($urandom);
      end
    for (int l = 0; l < 8; l++) begin
      rd_a[l] = 8'd0;
      rd_b[l] = 8'd0;
      c_ab[l] = 16'hdead;
    end
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.res_ready = 1'b0;

    // reset held three cycles
    for (int r = 0; r < 3; r++) begin
      cycle();
      chk("rst_ready", bus.cmd_ready, 1'b0);
      chk("rst_rd_en", bus.rd_en, 1'b0);
      chk("rst_rd_addr", bus.rd_addr, 8'h00);
      chk("rst_op_zero", bus.op_zero, 1'b1);
      chk("rst_c_sel", bus.c_sel, 1'b0);
      chk("rst_res_valid", bus.res_valid, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
    end
    rst = 1'b0;
    cycle();
    chk("rst_cab", cab_vec(), 128'd0);
    chk("rst_release_ready", bus.cmd_ready, 1'b1);

    // basic accumulate
    for (int i = 0; i < 3; i++) set_vec(8'h10 + 8'(i), 8'd2, 8'd3);
    run_cmd(8'h10, 3, 0);
    chk("basic_18", cab_vec(), {8{16'd18}});

    // wrap then back-to-back single beat
    set_vec(8'h00, 8'd5, 8'd5);
    run_cmd(8'hFE, 4, 0);
    run_cmd(8'h00, 1, 0);
    chk("b2b_25", cab_vec(), {8{16'd25}});

    // zero length
    run_cmd(8'h33, 0, 0);

    // backpressure
    run_cmd(8'h30, 2, 10);

    // reset mid-ISSUE
    begin
      int guard;
      guard = 0;
      while (bus.cmd_ready !== 1'b1 && guard < 64) begin
        cycle();
        guard++;
      end
      chk("mid_ready_wait", bus.cmd_ready, 1'b1);
      bus.cmd_valid = 1'b1;
      bus.cmd_base  = 8'h40;
      bus.cmd_len   = 8'd8;
      bus.res_ready = 1'b1;
      cycle();
      bus.cmd_valid = 1'b0;
      cycle();
      cycle();
      cycle();
      chk("mid_issuing", bus.rd_en, 1'b1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("mid_rd_en", bus.rd_en, 1'b0);
      chk("mid_res_valid", bus.res_valid, 1'b0);
      chk("mid_op_zero", bus.op_zero, 1'b1);
      chk("mid_busy", bus.busy, 1'b0);
      cycle();
      chk("mid_cab_clear", cab_vec(), 128'd0);
      chk("mid_rd_en2", bus.rd_en, 1'b0);
      exp_cab = '0;
      exp_q.delete();
      set_vec(8'h80, 8'd7, 8'd9);
      run_cmd(8'h80, 1, 0);
      chk("mid_fresh_63", cab_vec(), {8{16'd63}});
    end

    // random commands, including an occasional zero length and a maximum length
    for (int n = 0; n < 40; n++)
      run_cmd(8'($urandom), $urandom_range(0, 12), $urandom_range(0, 3));
    run_cmd(8'($urandom), 255, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
